// File: rtl/inst_fetch_cache.sv
// Direct-mapped read-only instruction cache with a line-refill FSM toward instruction memory.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module inst_fetch_cache #(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_ce,
    input  logic [ADDR_W-1:0] fetch_pc,
    input  logic              fetch_flush,
    output logic              stall,
    output logic              inst_valid,
    output logic [31:0]       inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [31:0]       mem_rdata
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int OFF    = WORD_W + 2;
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = ADDR_W - OFF - IDX_W;
    localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REFILL,
        S_RESP
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [ADDR_W-1:0]   miss_pc_q, miss_pc_d;
    logic [WORD_W-1:0]   beat_q, beat_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                inst_valid_q, inst_valid_d;
    logic [31:0]         inst_data_q, inst_data_d;
    logic [ADDR_W-1:0]   inst_pc_q, inst_pc_d;
    logic                flush_pend_q, flush_pend_d;

    logic [31:0]         data_mem [NUM_LINES*LINE_WORDS];
    logic [TAG_W-1:0]    tag_mem  [NUM_LINES];

    logic                data_we;
    logic                tag_we;

    // Address fields of the live fetch and of the latched miss.
    logic [IDX_W-1:0]    f_idx, m_idx;
    logic [WORD_W-1:0]   f_word, m_word;
    logic [TAG_W-1:0]    f_tag, m_tag;
    logic                hit;

    assign f_idx  = fetch_pc[OFF+IDX_W-1:OFF];
    assign f_word = fetch_pc[OFF-1:2];
    assign f_tag  = fetch_pc[ADDR_W-1:OFF+IDX_W];
    assign m_idx  = miss_pc_q[OFF+IDX_W-1:OFF];
    assign m_word = miss_pc_q[OFF-1:2];
    assign m_tag  = miss_pc_q[ADDR_W-1:OFF+IDX_W];

    assign hit = valid_q[f_idx] && (tag_mem[f_idx] == f_tag);

    // NOTE: every signal written here gets a default first so no latch is inferred;
    // blocking assignments are correct in combinational logic, flops use <= only.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        miss_pc_d    = miss_pc_q;
        beat_d       = beat_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        inst_valid_d = 1'b0;
        inst_data_d  = inst_data_q;
        inst_pc_d    = inst_pc_q;
        flush_pend_d = flush_pend_q;
        data_we      = 1'b0;
        tag_we       = 1'b0;
        stall        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                flush_pend_d = 1'b0;
                if (fetch_ce) begin
                    if (hit) begin
                        if (!fetch_flush) begin
                            inst_valid_d = 1'b1;
                            inst_data_d  = data_mem[{f_idx, f_word}];
                            inst_pc_d    = fetch_pc;
                        end
                    end else begin
                        // Stall in the same cycle so the PC unit holds the missing address.
                        stall        = 1'b1;
                        miss_pc_d    = fetch_pc;
                        mem_addr_d   = {fetch_pc[ADDR_W-1:OFF], {OFF{1'b0}}};
                        mem_req_d    = 1'b1;
                        beat_d       = '0;
                        valid_d[f_idx] = 1'b0;
                        flush_pend_d = fetch_flush;
                        state_d      = S_REFILL;
                    end
                end
            end

            S_REFILL: begin
                stall = 1'b1;
                if (fetch_flush) begin
                    flush_pend_d = 1'b1;
                end
                if (mem_valid) begin
                    data_we   = 1'b1;
                    mem_req_d = 1'b0;
                    beat_d    = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        tag_we         = 1'b1;
                        valid_d[m_idx] = 1'b1;
                        beat_d         = '0;
                        state_d        = S_RESP;
                    end
                end
            end

            S_RESP: begin
                stall = 1'b1;
                if (!(flush_pend_q || fetch_flush)) begin
                    inst_valid_d = 1'b1;
                    inst_data_d  = data_mem[{m_idx, m_word}];
                    inst_pc_d    = miss_pc_q;
                end
                flush_pend_d = 1'b0;
                state_d      = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            miss_pc_q    <= '0;
            beat_q       <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            inst_valid_q <= 1'b0;
            inst_data_q  <= '0;
            inst_pc_q    <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            miss_pc_q    <= miss_pc_d;
            beat_q       <= beat_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            inst_valid_q <= inst_valid_d;
            inst_data_q  <= inst_data_d;
            inst_pc_q    <= inst_pc_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // NOTE: the data and tag arrays are not reset; the per-line valid bits gate every
    // lookup, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (rst && data_we) begin
            data_mem[{m_idx, beat_q}] <= mem_rdata;
        end
        if (rst && tag_we) begin
            tag_mem[m_idx] <= m_tag;
        end
    end

    assign inst_valid = inst_valid_q;
    assign inst_data  = inst_data_q;
    assign inst_pc    = inst_pc_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == S_IDLE && fetch_ce && hit && !fetch_flush) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if (state_q == S_IDLE && state_d == S_REFILL) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule
